// File: rtl/key_filter_2ch.sv
// Two-channel push-button debouncer: sync, filter FSM, level and edge pulses.
// Define KEY_TOGGLE_EN to make key_level flip on each accepted press.
module key_filter_2ch #(
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] key_in,
    output logic [1:0] key_level,
    output logic [1:0] key_press,
    output logic [1:0] key_release
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        PRESSED,
        REL_FILT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CNT_MAX);

    logic [1:0] s1;
    logic [1:0] s2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 <= 2'b11;
            s2 <= 2'b11;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             cnt_done;
        logic             press_evt;
        logic             rel_evt;
        logic             level_q;
        logic             level_nxt;
        logic             press_q;
        logic             rel_q;

        assign cnt_done = (cnt == CNT_END);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state   <= IDLE;
                cnt     <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                level_q <= level_nxt;
                press_q <= press_evt;
                rel_q   <= rel_evt;
            end
        end

        // s2 is active-low: 0 means the button is held.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            unique case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (!s2[i]) state_nxt = PRESS_FILT;
                end
                PRESS_FILT: begin
                    if (s2[i]) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt_done) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    cnt_nxt = '0;
                    if (s2[i]) state_nxt = REL_FILT;
                end
                REL_FILT: begin
                    if (!s2[i]) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt_done) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_comb begin
            press_evt = (state == PRESS_FILT) && !s2[i] && cnt_done;
            rel_evt   = (state == REL_FILT) && s2[i] && cnt_done;
`ifdef KEY_TOGGLE_EN
            level_nxt = level_q ^ press_evt;
`else
            level_nxt = level_q;
            if (press_evt) level_nxt = 1'b1;
            if (rel_evt)   level_nxt = 1'b0;
`endif
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
    end

endmodule
